event_stretcher: RTL and testbench

- Output-side counterpart to the button debouncer. The debouncer turns slow human input into one-cycle pulses; this block turns one-cycle game events into human-visible LED pulses.
- Input: single-cycle event pulses (card dealt, bust, win) from the blackjack control logic.
- Output: one fixed-length LED on-pulse per event, followed by a fixed off-gap.
- Events that arrive while a pulse is playing are queued in a saturating counter and replayed in order.

---
 rtl/event_stretcher_pkg.sv | 25 ++
 rtl/event_stretcher_tick_divider.sv | 37 +++
 rtl/event_stretcher.sv | 132 +++++++++++++
 tb/tb_event_stretcher.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_stretcher_pkg.sv
// ---------------------------------------------------------------------------
// event_stretcher_pkg
// Shared definitions for the LED / feedback pulse drivers.
//   stretch_state_t : FSM encoding (IDLE=0, ON=1, GAP=2)
//   DEF_*           : default timing constants (slow tick = debouncer rate)
//   max_int         : helper for sizing counters from two parameters
// ---------------------------------------------------------------------------
package event_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } stretch_state_t;

  localparam int DEF_TICK_DIV  = 100;
  localparam int DEF_ON_TICKS  = 4;
  localparam int DEF_OFF_TICKS = 2;
  localparam int DEF_PEND_W    = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_stretcher_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running 0..TICK_DIV-1 cycle counter producing a one-cycle slow tick.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous restart of the count (used on every FSM state entry)
//   tick : high while the count equals TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_divider
  import event_stretcher_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/event_stretcher.sv
// ---------------------------------------------------------------------------
// event_stretcher
// Turns one-cycle game events into fixed-length, human-visible LED pulses
// separated by a fixed off-gap. Events arriving while a pulse plays are
// queued in a saturating counter and replayed in order.
//   clk         : system clock
//   rst         : synchronous active-high reset (aborts any pulse, drops queue)
//   event_pulse : event strobe, one event per high cycle
//   led_out     : stretched pulse (high in ON)
//   busy        : high whenever the FSM is not IDLE
//   pending     : queued, not-yet-played events
//   overflow    : sticky flag, set when an event is dropped at saturation
// ---------------------------------------------------------------------------
module event_stretcher
  import event_stretcher_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int PEND_W    = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_pulse,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int TC_W = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);
  localparam logic [TC_W-1:0]   ON_LAST  = TC_W'(ON_TICKS - 1);
  localparam logic [TC_W-1:0]   OFF_LAST = TC_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  stretch_state_t    state_reg, state_next;
  logic [TC_W-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [PEND_W-1:0] pend_reg, pend_next;
  logic              ovf_reg, ovf_next;
  logic              tick;
  logic              state_clr;
  logic              consume_queued;
  logic              queue_live;

  // Restarting the divider on every state entry makes each state's length
  // an exact multiple of TICK_DIV regardless of when the event arrived.
  assign state_clr = (state_next != state_reg);

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk (clk),
    .rst (rst),
    .clr (state_clr),
    .tick(tick)
  );

  // In IDLE a queued event is always served first; a live event that is
  // not taken directly by IDLE->ON goes into the queue instead.
  assign consume_queued = (state_reg == ST_IDLE) && (pend_reg != '0);
  assign queue_live     = event_pulse && !((state_reg == ST_IDLE) && (pend_reg == '0));

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (event_pulse || (pend_reg != '0)) begin
          state_next = ST_ON;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (tick_cnt_reg == ON_LAST) begin
            state_next = ST_GAP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (tick_cnt_reg == OFF_LAST) begin
            state_next = ST_IDLE;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (state_next != state_reg) begin
      tick_cnt_next = '0;
    end
  end

  always_comb begin
    pend_next = pend_reg;
    ovf_next  = ovf_reg;
    if (queue_live && !consume_queued) begin
      if (pend_reg == PEND_MAX) begin
        ovf_next = 1'b1;
      end else begin
        pend_next = pend_reg + 1'b1;
      end
    end else if (consume_queued && !queue_live) begin
      pend_next = pend_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      pend_reg     <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      pend_reg     <= pend_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign led_out  = (state_reg == ST_ON);
  assign busy     = (state_reg != ST_IDLE);
  assign pending  = pend_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_event_stretcher.sv
// Scoreboard bench: each scenario pushes hand-computed expected samples and
// LED pulses (cycle numbers relative to the cycle reset is released); the
// negedge monitor pops and compares as the DUT reaches those points.
module tb_event_stretcher;

  localparam int PW = 3;
  localparam int K_LED = 0, K_BUSY = 1, K_PEND = 2, K_OVF = 3;

  typedef struct {
    int t;
    int kind;
    int val;
  } samp_t;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          event_pulse = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int failures = 0;

  samp_t  sq[$];
  pulse_t pq[$];

  event_stretcher #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(1),
    .PEND_W   (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .event_pulse(event_pulse),
    .led_out    (led_out),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_LED:   return "led_out";
      K_BUSY:  return "busy";
      K_PEND:  return "pending";
      default: return "overflow";
    endcase
  endfunction

  function automatic int read_kind(input int k);
    case (k)
      K_LED:   return int'(led_out);
      K_BUSY:  return int'(busy);
      K_PEND:  return int'(pending);
      default: return int'(overflow);
    endcase
  endfunction

  // ---------------- monitor ----------------
  int     mon_t;
  int     mon_start;
  int     mon_act;
  int     pend_prev = 0;
  logic   led_prev = 1'b0;
  samp_t  sexp;
  pulse_t pexp;

  always @(negedge clk) begin
    mon_t = cyc - base;
    while (sq.size() > 0 && sq[0].t <= mon_t) begin
      sexp = sq.pop_front();
      checks++;
      if (sexp.t < mon_t) begin
        failures++;
        $display("FAIL %s@%0d: sample point missed (now cycle %0d)", kname(sexp.kind), sexp.t, mon_t);
      end else begin
        mon_act = read_kind(sexp.kind);
        if (mon_act != sexp.val) begin
          failures++;
          $display("FAIL %s@%0d: got %0d expected %0d", kname(sexp.kind), sexp.t, mon_act, sexp.val);
        end
      end
    end

    if (led_out && !led_prev) mon_start = mon_t;
    if (!led_out && led_prev) begin
      if (pq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pulse_unexpected: got start=%0d len=%0d expected no pulse", mon_start, mon_t - mon_start);
      end else begin
        pexp = pq.pop_front();
        checks += 2;
        $display("pulse start=%0d len=%0d (expected start=%0d len=%0d)", mon_start, mon_t - mon_start, pexp.start, pexp.len);
        if (mon_start != pexp.start) begin
          failures++;
          $display("FAIL pulse_start: got %0d expected %0d", mon_start, pexp.start);
        end
        if ((mon_t - mon_start) != pexp.len) begin
          failures++;
          $display("FAIL pulse_len: got %0d expected %0d", mon_t - mon_start, pexp.len);
        end
      end
    end
    led_prev = led_out;

    // The queue counter must never wrap from empty to full.
    if (pend_prev == 0 && int'(pending) == (1 << PW) - 1) begin
      failures++;
      $display("FAIL pending_wrap: got %0d after 0 expected no underflow", int'(pending));
    end
    pend_prev = int'(pending);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_cyc(input int c);
    int d;
    d = c - (cyc - base);
    if (d > 0) step(d);
  endtask

  task automatic exp_s(input int t, input int k, input int v);
    samp_t s;
    s.t = t;
    s.kind = k;
    s.val = v;
    sq.push_back(s);
  endtask

  task automatic exp_p(input int s, input int l);
    pulse_t p;
    p.start = s;
    p.len = l;
    pq.push_back(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    event_pulse = 1'b0;
    step(2);
    rst = 1'b0;
    base = cyc;
    exp_s(0, K_LED, 0);
    exp_s(0, K_BUSY, 0);
    exp_s(0, K_PEND, 0);
    exp_s(0, K_OVF, 0);
  endtask

  task automatic pulse_hold(input int c, input int n);
    goto_cyc(c);
    event_pulse = 1'b1;
    step(n);
    event_pulse = 1'b0;
  endtask

  task automatic end_scn(input int c, input string name);
    goto_cyc(c);
    checks++;
    if (sq.size() != 0) begin
      failures++;
      $display("FAIL %s_samples_left: got %0d expected 0", name, sq.size());
      sq.delete();
    end
    checks++;
    if (pq.size() != 0) begin
      failures++;
      $display("FAIL %s_pulses_missing: got %0d expected 0", name, pq.size());
      pq.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // Single event at 10: ON 11..18, GAP 19..22, IDLE from 23.
    do_reset();
    exp_s(10, K_LED, 0);  exp_s(10, K_BUSY, 0);
    exp_s(11, K_LED, 1);  exp_s(11, K_BUSY, 1);
    exp_s(15, K_PEND, 0); exp_s(18, K_LED, 1);
    exp_s(19, K_LED, 0);  exp_s(22, K_BUSY, 1);
    exp_s(23, K_BUSY, 0);
    exp_p(11, 8);
    pulse_hold(10, 1);
    end_scn(30, "single");

    // Burst 10,11,12 as separate strobes; replay period 13 cycles.
    do_reset();
    exp_s(12, K_PEND, 1); exp_s(13, K_PEND, 2);
    exp_s(23, K_PEND, 2); exp_s(24, K_PEND, 1);
    exp_s(36, K_PEND, 1); exp_s(37, K_PEND, 0);
    exp_s(45, K_OVF, 0);  exp_s(48, K_BUSY, 1);
    exp_s(49, K_BUSY, 0);
    exp_p(11, 8); exp_p(24, 8); exp_p(37, 8);
    pulse_hold(10, 1);
    pulse_hold(11, 1);
    pulse_hold(12, 1);
    end_scn(55, "burst");

    // Saturation: event at 10 plus 9 while busy; 7 queue, 2 dropped.
    do_reset();
    exp_s(18, K_PEND, 7); exp_s(18, K_OVF, 0);
    exp_s(19, K_OVF, 1);  exp_s(20, K_PEND, 7);
    exp_s(24, K_PEND, 6); exp_s(89, K_PEND, 1);
    exp_s(102, K_PEND, 0); exp_s(113, K_BUSY, 1);
    exp_s(114, K_BUSY, 0); exp_s(120, K_OVF, 1);
    for (int i = 0; i < 8; i++) exp_p(11 + 13 * i, 8);
    pulse_hold(10, 10);
    end_scn(125, "saturate");

    // Simultaneous: IDLE at 23 with pending=1 and a live event.
    do_reset();
    exp_s(12, K_PEND, 1); exp_s(23, K_PEND, 1);
    exp_s(23, K_BUSY, 0); exp_s(24, K_PEND, 1);
    exp_s(24, K_LED, 1);  exp_s(36, K_PEND, 1);
    exp_s(37, K_PEND, 0);
    exp_p(11, 8); exp_p(24, 8); exp_p(37, 8);
    pulse_hold(10, 2);
    pulse_hold(23, 1);
    end_scn(55, "simul");

    // Reset during 3rd cycle (26) of second ON with pending=3.
    do_reset();
    exp_s(15, K_PEND, 4); exp_s(24, K_PEND, 3);
    exp_s(26, K_PEND, 3); exp_s(26, K_LED, 1);
    exp_s(27, K_LED, 0);  exp_s(27, K_BUSY, 0);
    exp_s(27, K_PEND, 0); exp_s(27, K_OVF, 0);
    exp_s(38, K_LED, 1);  exp_s(45, K_PEND, 0);
    exp_s(45, K_LED, 1);  exp_s(46, K_LED, 0);
    exp_s(49, K_BUSY, 1); exp_s(50, K_BUSY, 0);
    exp_p(11, 8); exp_p(24, 3); exp_p(38, 8);
    pulse_hold(10, 5);
    goto_cyc(26);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pulse_hold(37, 1);
    end_scn(60, "midreset");

    // Held input: high for 3 cycles from IDLE.
    do_reset();
    exp_s(11, K_LED, 1);  exp_s(12, K_PEND, 1);
    exp_s(13, K_PEND, 2); exp_s(25, K_PEND, 1);
    exp_s(38, K_PEND, 0);
    exp_p(11, 8); exp_p(24, 8); exp_p(37, 8);
    pulse_hold(10, 3);
    end_scn(55, "held");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
